bram_writer: RTL and testbench
==============================

Name: bram_writer

Overview:
- Streaming write master for a Xilinx BRAM_CTRL-style port (32-bit data, 4-bit byte write enables, byte addressing).
- Accepts DATA_IN_WIDTH-bit result elements over a valid/ready handshake and packs them little-endian into 32-bit words.
- Writes each word to consecutive BRAM word addresses starting at a programmed base address.
- Used by the fish box datapath to return computed output pixels to PS-visible BRAM. It is the write-side counterpart of the existing BRAM read path.

Parameters:
- DATA_IN_WIDTH, 8, element width; legal values are 8, 16, 32. LANES = 32/DATA_IN_WIDTH.
- MEM_BYTES, 32768, BRAM size in bytes (power of 2). The address offset wraps modulo this value.
- CNT_WIDTH, 32, width of the element count and counters.

Ports:
- i_clk  in  1  clock for all logic and the BRAM port
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  1-cycle pulse; begins a transfer; honoured only in IDLE or DONE
- i_base_addr  in  32  byte address of the first word; must be 4-byte aligned, bits [1:0] ignored
- i_num_elems  in  CNT_WIDTH  number of elements to write; sampled on the accepted i_start
- i_data  in  DATA_IN_WIDTH  element data
- i_valid  in  1  element valid
- o_ready  out  1  element ready; a transfer occurs when i_valid && o_ready
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  sticky completion flag; cleared by the next accepted i_start
- o_elem_count  out  CNT_WIDTH  number of elements accepted in the current or last transfer
- bram_clk  out  1  = i_clk
- bram_rst  out  1  = i_rst
- bram_en  out  1  write strobe
- bram_we  out  4  byte enables; 0 whenever bram_en=0
- bram_addr  out  32  byte address
- bram_din  out  32  write data; unfilled lanes are 0

Behaviour:
- Reset value of every registered output is 0: o_ready, o_busy, o_done, o_elem_count, bram_en, bram_we, bram_addr, bram_din. State resets to IDLE.
- States:
  - IDLE: waiting for i_start.
  - RUN: accepting elements.
  - DRAIN: issuing the final write.
  - DONE: o_done=1, waiting for the next i_start.
- Transitions:
  - IDLE/DONE + i_start with i_num_elems>0 -> RUN. On the same edge: clear o_done and o_elem_count, latch base and count, clear lane pointer and word offset.
  - IDLE/DONE + i_start with i_num_elems==0 -> DONE on the next cycle. No BRAM write.
  - RUN with last element accepted -> DRAIN. DRAIN -> DONE after one cycle.
- o_ready is 1 only in RUN while accepted < count. It deasserts the cycle after the final element is accepted.
- Packing:
  - Element k goes to lane (k mod LANES), at bits [lane*W +: W].
  - Its word address is base + ((4*(k/LANES)) mod MEM_BYTES).
  - Lane 0 occupies the least-significant bits.
- Write issue:
  - When a lane fill completes a word, or the final element is accepted, bram_en=1 for exactly one cycle, on the cycle after that accept (registered).
  - bram_we = byte mask of the filled lanes: 4'hF for a full word; for a partial final word, only the filled lanes, e.g. 8-bit with 2 lanes filled -> 4'h3, 16-bit with 1 lane filled -> 4'h3.
  - The word offset then advances by 4.
- Throughput is 1 element per cycle. The BRAM never back-pressures, so a write can coincide with acceptance of the next word's first element.
- i_valid gaps leave the partial word held and emit no write.
- o_done rises on the cycle after the final bram_en pulse (2 cycles after the last accept) and stays high until the next accepted i_start.
- i_start in RUN or DRAIN is ignored, and the latched base and count are unchanged.
- Wrap: the offset wraps modulo MEM_BYTES. For example, base 0x7FFC with 2 full words writes 0x7FFC then 0x0000, i.e. bram_addr = base with offset bits replaced.
- Reset mid-transfer: the next edge returns to IDLE with all outputs 0. The held partial word is discarded and no write is emitted.
- o_elem_count increments on each accept and saturates at the latched count.

Decomposition:
- Shared package fish_box_pkg holds:
  - BRAM_DATA_WIDTH=32, BRAM_WE_WIDTH=4
  - the writer state encoding (IDLE, RUN, DRAIN, DONE)
  - a lane-mask function (lanes filled, DATA_IN_WIDTH) -> 4-bit byte enable
- One natural sub-module: lane_packer. It holds the shift-in lane register, the lane pointer, and the word-complete/partial flag. The FSM, addressing and BRAM port live in the top module.

Test Plan:
- W=8, base 0x100, 8 elements 0x01..0x08 back-to-back -> writes at 0x100 din 0x04030201 we F and at 0x104 din 0x08070605 we F; o_done 2 cycles after the 8th accept; o_elem_count=8.
- W=16, base 0x0, 3 elements 0xAAAA, 0xBBBB, 0xCCCC -> write at 0x0 din 0xBBBBAAAA we F, then at 0x4 din 0x0000CCCC we 3.
- W=8, i_num_elems=0, i_start -> o_done=1 next cycle; bram_en never asserted; o_ready stays 0.
- W=8, 4 elements with i_valid low for 3 cycles between elements 2 and 3, plus i_start pulsed mid-transfer -> single write 0x44332211 we F at base; the extra start has no effect.
- W=32, base 0x7FFC, 2 elements -> writes at 0x7FFC then 0x0000.
- W=8, i_rst pulsed after 3 of 8 accepts -> next cycle all outputs 0 and state IDLE, no write; a fresh i_start then runs normally.

Source files
------------

// File: rtl/fish_box_pkg.sv
// Shared definitions for the fish box datapath: BRAM port geometry,
// writer FSM state encoding and the lane-to-byte-enable helper.
package fish_box_pkg;

    localparam int BRAM_DATA_WIDTH = 32;
    localparam int BRAM_WE_WIDTH   = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Byte enables covering the first `lanes` lanes of `width` bits.
    function automatic logic [BRAM_WE_WIDTH-1:0] lane_mask(
        input int unsigned lanes,
        input int unsigned width
    );
        int unsigned nbytes;
        logic [BRAM_WE_WIDTH-1:0] m;
        nbytes = (lanes * width) / 8;
        m = '0;
        for (int unsigned i = 0; i < BRAM_WE_WIDTH; i++) begin
            if (i < nbytes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bram_writer_lane_packer.sv
// Packs DATA_IN_WIDTH elements little-endian into a 32-bit word.
// Ports: i_clk/i_rst, i_clear (new transfer), i_push (element accepted),
// i_last (final element), i_data; o_word (word incl. current element),
// o_fill (lanes filled incl. current), o_complete (word ready to write).
module lane_packer
    import fish_box_pkg::*;
#(
    parameter int DATA_IN_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic                       i_last,
    input  logic [DATA_IN_WIDTH-1:0]   i_data,
    output logic [BRAM_DATA_WIDTH-1:0] o_word,
    output logic [2:0]                 o_fill,
    output logic                       o_complete
);

    localparam int LANES = BRAM_DATA_WIDTH / DATA_IN_WIDTH;
    localparam int PW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic [BRAM_DATA_WIDTH-1:0] lane_q;
    logic [BRAM_DATA_WIDTH-1:0] word_next;
    logic [PW-1:0]              ptr_q;
    logic                       at_top;

    always_comb begin
        word_next = lane_q;
        word_next[ptr_q*DATA_IN_WIDTH +: DATA_IN_WIDTH] = i_data;
    end

    assign at_top     = (ptr_q == PW'(LANES - 1));
    assign o_complete = i_push && (at_top || i_last);
    assign o_word     = word_next;
    assign o_fill     = 3'(ptr_q) + 3'd1;

    // A completed word is handed out combinationally, so the register
    // restarts empty and the next element may land in lane 0 at once.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            lane_q <= '0;
            ptr_q  <= '0;
        end else if (i_push) begin
            if (o_complete) begin
                lane_q <= '0;
                ptr_q  <= '0;
            end else begin
                lane_q <= word_next;
                ptr_q  <= ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_writer.sv
// Streaming BRAM write master: packs elements into words and writes them
// to consecutive word addresses from a programmed base.
// Ports: i_clk/i_rst, i_start/i_base_addr/i_num_elems (transfer setup),
// i_data/i_valid/o_ready (element stream), o_busy/o_done/o_elem_count
// (status), bram_* (BRAM_CTRL-style write port).
module bram_writer
    import fish_box_pkg::*;
#(
    parameter int DATA_IN_WIDTH = 8,
    parameter int MEM_BYTES     = 32768,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [31:0]              i_base_addr,
    input  logic [CNT_WIDTH-1:0]     i_num_elems,
    input  logic [DATA_IN_WIDTH-1:0] i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_WIDTH-1:0]     o_elem_count,
    output logic                     bram_clk,
    output logic                     bram_rst,
    output logic                     bram_en,
    output logic [3:0]               bram_we,
    output logic [31:0]              bram_addr,
    output logic [31:0]              bram_din
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [1:0]           state_q;
    logic [31:0]          base_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [AW-1:0]        off_q;
    logic [AW-1:0]        addr_lo;

    logic        start_ok;
    logic        accept;
    logic        last;
    logic [31:0] word;
    logic [2:0]  fill;
    logic        complete;

    assign bram_clk = i_clk;
    assign bram_rst = i_rst;

    assign start_ok = i_start &&
                      (state_q == ST_IDLE || state_q == ST_DONE);
    assign accept   = i_valid && o_ready;
    assign last     = accept &&
                      (o_elem_count == count_q - 1'b1);

    // Offset wraps inside the BRAM; upper base bits pass through.
    assign addr_lo  = base_q[AW-1:0] + off_q;

    lane_packer #(
        .DATA_IN_WIDTH (DATA_IN_WIDTH)
    ) u_packer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (start_ok),
        .i_push     (accept),
        .i_last     (last),
        .i_data     (i_data),
        .o_word     (word),
        .o_fill     (fill),
        .o_complete (complete)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            count_q      <= '0;
            off_q        <= '0;
            o_ready      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_elem_count <= '0;
            bram_en      <= 1'b0;
            bram_we      <= '0;
            bram_addr    <= '0;
            bram_din     <= '0;
        end else begin
            bram_en <= 1'b0;
            bram_we <= '0;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        o_elem_count <= '0;
                        base_q       <= i_base_addr & ~32'h3;
                        count_q      <= i_num_elems;
                        off_q        <= '0;
                        if (i_num_elems != '0) begin
                            state_q <= ST_RUN;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b1;
                            o_done  <= 1'b0;
                        end else begin
                            state_q <= ST_DONE;
                            o_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept && o_elem_count < count_q) begin
                        o_elem_count <= o_elem_count + 1'b1;
                    end
                    if (last) begin
                        o_ready <= 1'b0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (complete) begin
                bram_en   <= 1'b1;
                bram_we   <= lane_mask(32'(fill), DATA_IN_WIDTH);
                bram_din  <= word;
                bram_addr <= {base_q[31:AW], addr_lo};
                off_q     <= off_q + AW'(4);
            end
        end
    end

endmodule

// File: tb/tb_bram_writer.sv
// Scoreboard bench for bram_writer at 8, 16 and 32-bit element widths.
// Expected writes are queued per instance and checked on each bram_en.
module tb_bram_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // {addr, din, we}
    logic [67:0] q8[$];
    logic [67:0] q16[$];
    logic [67:0] q32[$];
    logic [67:0] e8, e16, e32;

    logic        s8, v8, r8, bz8, dn8, bc8, br8, en8;
    logic [31:0] b8, n8, c8, a8, di8;
    logic [7:0]  d8;
    logic [3:0]  we8;

    logic        s16, v16, r16, bz16, dn16, bc16, br16, en16;
    logic [31:0] b16, n16, c16, a16, di16;
    logic [15:0] d16;
    logic [3:0]  we16;

    logic        s32, v32, r32, bz32, dn32, bc32, br32, en32;
    logic [31:0] b32, n32, c32, a32, di32, d32;
    logic [3:0]  we32;

    bram_writer #(.DATA_IN_WIDTH(8)) u8 (
        .i_clk(clk), .i_rst(rst), .i_start(s8),
        .i_base_addr(b8), .i_num_elems(n8),
        .i_data(d8), .i_valid(v8), .o_ready(r8),
        .o_busy(bz8), .o_done(dn8), .o_elem_count(c8),
        .bram_clk(bc8), .bram_rst(br8), .bram_en(en8),
        .bram_we(we8), .bram_addr(a8), .bram_din(di8)
    );

    bram_writer #(.DATA_IN_WIDTH(16)) u16 (
        .i_clk(clk), .i_rst(rst), .i_start(s16),
        .i_base_addr(b16), .i_num_elems(n16),
        .i_data(d16), .i_valid(v16), .o_ready(r16),
        .o_busy(bz16), .o_done(dn16), .o_elem_count(c16),
        .bram_clk(bc16), .bram_rst(br16), .bram_en(en16),
        .bram_we(we16), .bram_addr(a16), .bram_din(di16)
    );

    bram_writer #(.DATA_IN_WIDTH(32)) u32 (
        .i_clk(clk), .i_rst(rst), .i_start(s32),
        .i_base_addr(b32), .i_num_elems(n32),
        .i_data(d32), .i_valid(v32), .o_ready(r32),
        .o_busy(bz32), .o_done(dn32), .o_elem_count(c32),
        .bram_clk(bc32), .bram_rst(br32), .bram_en(en32),
        .bram_we(we32), .bram_addr(a32), .bram_din(di32)
    );

    always @(negedge clk) begin
        if (en8) begin
            n_tests++;
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL w8_write unexpected a=%h d=%h we=%h required none",
                         a8, di8, we8);
            end else begin
                e8 = q8.pop_front();
                if ({a8, di8, we8} !== e8) begin
                    n_fail++;
                    $display("FAIL w8_write got %h/%h/%h required %h/%h/%h",
                             a8, di8, we8, e8[67:36], e8[35:4], e8[3:0]);
                end
            end
        end
        if (en16) begin
            n_tests++;
            if (q16.size() == 0) begin
                n_fail++;
                $display("FAIL w16_write unexpected a=%h d=%h we=%h required none",
                         a16, di16, we16);
            end else begin
                e16 = q16.pop_front();
                if ({a16, di16, we16} !== e16) begin
                    n_fail++;
                    $display("FAIL w16_write got %h/%h/%h required %h/%h/%h",
                             a16, di16, we16, e16[67:36], e16[35:4], e16[3:0]);
                end
            end
        end
        if (en32) begin
            n_tests++;
            if (q32.size() == 0) begin
                n_fail++;
                $display("FAIL w32_write unexpected a=%h d=%h we=%h required none",
                         a32, di32, we32);
            end else begin
                e32 = q32.pop_front();
                if ({a32, di32, we32} !== e32) begin
                    n_fail++;
                    $display("FAIL w32_write got %h/%h/%h required %h/%h/%h",
                             a32, di32, we32, e32[67:36], e32[35:4], e32[3:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({r8, bz8, dn8, en8, we8} !== 8'h0 || c8 !== 0 ||
            a8 !== 0 || di8 !== 0) begin
            n_fail++;
            $display("FAIL reset_w8 got r=%b b=%b d=%b en=%b we=%h c=%0d a=%h din=%h required all 0",
                     r8, bz8, dn8, en8, we8, c8, a8, di8);
        end
        n_tests++;
        if ({r16, bz16, dn16, en16, r32, bz32, dn32, en32} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_w16_w32 got %b required 00000000",
                     {r16, bz16, dn16, en16, r32, bz32, dn32, en32});
        end
        n_tests++;
        if ({bc8, bc16, bc32} !== {3{clk}} || {br8, br16, br32} !== 3'b111) begin
            n_fail++;
            $display("FAIL bram_clk_rst got clk=%b rst=%b required %b 111",
                     {bc8, bc16, bc32}, {br8, br16, br32}, {3{clk}});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        s8 = 1'b1; b8 = 32'h80; n8 = 0;
        @(negedge clk);
        s8 = 1'b0;
        n_tests++;
        if (dn8 !== 1'b1 || r8 !== 1'b0 || bz8 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_count got done=%b ready=%b busy=%b required 1 0 0",
                     dn8, r8, bz8);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (dn8 !== 1'b1 || r8 !== 1'b0 || c8 !== 0) begin
            n_fail++;
            $display("FAIL zero_hold got done=%b ready=%b cnt=%0d required 1 0 0",
                     dn8, r8, c8);
        end
    endtask

    task automatic test_back_to_back();
        s8 = 1'b1; b8 = 32'h100; n8 = 8;
        q8.push_back({32'h100, 32'h04030201, 4'hF});
        q8.push_back({32'h104, 32'h08070605, 4'hF});
        @(negedge clk);
        s8 = 1'b0;
        n_tests++;
        if (r8 !== 1'b1 || bz8 !== 1'b1 || dn8 !== 1'b0 || c8 !== 0) begin
            n_fail++;
            $display("FAIL b2b_start got ready=%b busy=%b done=%b cnt=%0d required 1 1 0 0",
                     r8, bz8, dn8, c8);
        end
        for (int k = 1; k <= 8; k++) begin
            d8 = 8'(k); v8 = 1'b1;
            @(negedge clk);
        end
        v8 = 1'b0;
        n_tests++;
        if (r8 !== 1'b0 || dn8 !== 1'b0 || bz8 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_drain got ready=%b done=%b busy=%b required 0 0 1",
                     r8, dn8, bz8);
        end
        @(negedge clk);
        n_tests++;
        if (dn8 !== 1'b1 || bz8 !== 1'b0 || c8 !== 8) begin
            n_fail++;
            $display("FAIL b2b_done got done=%b busy=%b cnt=%0d required 1 0 8",
                     dn8, bz8, c8);
        end
    endtask

    task automatic test_partial_word();
        s16 = 1'b1; b16 = 32'h0; n16 = 3;
        q16.push_back({32'h0, 32'hBBBBAAAA, 4'hF});
        q16.push_back({32'h4, 32'h0000CCCC, 4'h3});
        @(negedge clk);
        s16 = 1'b0;
        v16 = 1'b1; d16 = 16'hAAAA; @(negedge clk);
        d16 = 16'hBBBB; @(negedge clk);
        d16 = 16'hCCCC; @(negedge clk);
        v16 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dn16 !== 1'b1 || c16 !== 3 || r16 !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_done got done=%b cnt=%0d ready=%b required 1 3 0",
                     dn16, c16, r16);
        end
    endtask

    task automatic test_gap_and_restart();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22;
        vals[2] = 8'h33; vals[3] = 8'h44;
        s8 = 1'b1; b8 = 32'h200; n8 = 4;
        q8.push_back({32'h200, 32'h44332211, 4'hF});
        @(negedge clk);
        s8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                v8 = 1'b0;
                @(negedge clk);
                s8 = 1'b1; b8 = 32'h300; n8 = 1;
                @(negedge clk);
                s8 = 1'b0;
                @(negedge clk);
                n_tests++;
                if (r8 !== 1'b1 || c8 !== 2 || bz8 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_hold got ready=%b cnt=%0d busy=%b required 1 2 1",
                             r8, c8, bz8);
                end
            end
            d8 = vals[k]; v8 = 1'b1;
            @(negedge clk);
        end
        v8 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dn8 !== 1'b1 || c8 !== 4) begin
            n_fail++;
            $display("FAIL gap_done got done=%b cnt=%0d required 1 4",
                     dn8, c8);
        end
    endtask

    task automatic test_wrap();
        s32 = 1'b1; b32 = 32'h7FFC; n32 = 2;
        q32.push_back({32'h7FFC, 32'hDEADBEEF, 4'hF});
        q32.push_back({32'h0000, 32'h12345678, 4'hF});
        @(negedge clk);
        s32 = 1'b0;
        v32 = 1'b1; d32 = 32'hDEADBEEF; @(negedge clk);
        d32 = 32'h12345678; @(negedge clk);
        v32 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dn32 !== 1'b1 || c32 !== 2) begin
            n_fail++;
            $display("FAIL wrap_done got done=%b cnt=%0d required 1 2",
                     dn32, c32);
        end
    endtask

    task automatic test_reset_mid();
        s8 = 1'b1; b8 = 32'h400; n8 = 8;
        @(negedge clk);
        s8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d8 = 8'hE0 + 8'(k); v8 = 1'b1;
            @(negedge clk);
        end
        v8 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({r8, bz8, dn8, en8, we8} !== 8'h0 || c8 !== 0 ||
            a8 !== 0 || di8 !== 0) begin
            n_fail++;
            $display("FAIL reset_mid got r=%b b=%b d=%b en=%b we=%h c=%0d a=%h din=%h required all 0",
                     r8, bz8, dn8, en8, we8, c8, a8, di8);
        end
        @(negedge clk);
        s8 = 1'b1; b8 = 32'h400; n8 = 4;
        q8.push_back({32'h400, 32'hA4A3A2A1, 4'hF});
        @(negedge clk);
        s8 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            d8 = 8'hA0 + 8'(k); v8 = 1'b1;
            @(negedge clk);
        end
        v8 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dn8 !== 1'b1 || c8 !== 4) begin
            n_fail++;
            $display("FAIL reset_rerun got done=%b cnt=%0d required 1 4",
                     dn8, c8);
        end
    endtask

    initial begin
        s8 = 0; v8 = 0; b8 = 0; n8 = 0; d8 = 0;
        s16 = 0; v16 = 0; b16 = 0; n16 = 0; d16 = 0;
        s32 = 0; v32 = 0; b32 = 0; n32 = 0; d32 = 0;
        @(negedge clk);
        test_reset();
        test_zero_count();
        test_back_to_back();
        test_partial_word();
        test_gap_and_restart();
        test_wrap();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_tests++;
        if (q8.size() != 0 || q16.size() != 0 || q32.size() != 0) begin
            n_fail++;
            $display("FAIL missing_writes got pending %0d/%0d/%0d required 0/0/0",
                     q8.size(), q16.size(), q32.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
